// File: rtl/sensors_height_filter_if.sv
// Snapshot-in / filtered-height-out bundle for sensors_height_filter.
// A snapshot transfers on a rising edge where in_valid && in_ready. The master keeps sensors
// stable while in_valid is high. height_valid is a one-cycle strobe with no backpressure.
interface sensors_height_filter_if #(
    parameter int WIDTH     = 8,
    parameter int NUM_PAIRS = 2
);
    logic [2*NUM_PAIRS*WIDTH-1:0]       sensors;
    logic                               in_valid;
    logic                               in_ready;
    logic [WIDTH-1:0]                   height;
    logic                               height_valid;
    logic [$clog2(NUM_PAIRS+1)-1:0]     pairs_used;
    logic                               fault;
    logic [1:0]                         state_dbg;

    modport master (
        output sensors, in_valid,
        input  in_ready, height, height_valid, pairs_used, fault, state_dbg
    );

    modport slave (
        input  sensors, in_valid,
        output in_ready, height, height_valid, pairs_used, fault, state_dbg
    );
endinterface

// File: rtl/sensors_height_filter.sv
// Sequential height estimator: drops failed opposing pairs, takes the rounded mean of the
// surviving readings with a bit-serial divider, then smooths it over a moving window.
module sensors_height_filter #(
    parameter int WIDTH     = 8,
    parameter int NUM_PAIRS = 2,
    parameter int AVG_LOG2  = 2
) (
    input logic                    clk,
    input logic                    rst,
    sensors_height_filter_if.slave bus
);
    localparam int NS    = 2 * NUM_PAIRS;
    localparam int SUMW  = WIDTH + $clog2(NS);
    localparam int CW    = $clog2(NS + 1);
    localparam int PW    = $clog2(NUM_PAIRS + 1);
    localparam int BW    = $clog2(SUMW);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int WSW   = WIDTH + AVG_LOG2;

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
    state_t state, state_nx;

    logic [NS*WIDTH-1:0] snap;
    logic [SUMW-1:0]     sum, num, rem, rem_nx, num_nx;
    logic [SUMW:0]       rem_sh;
    logic                ge;
    logic [CW-1:0]       cnt;
    logic [PW-1:0]       ptr;
    logic [BW-1:0]       bcnt;
    logic [WIDTH-1:0]    pa, pb, q;
    logic                pair_ok, scan_last;

    logic [WIDTH-1:0]    win [DEPTH];
    logic                win_full;
    logic [WSW-1:0]      wsum;
    logic [WIDTH-1:0]    height_nx;

    logic [WIDTH-1:0]    height_r;
    logic                height_valid_r, fault_r;
    logic [PW-1:0]       pairs_used_r;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.in_valid) state_nx = SCAN;
            SCAN: if (scan_last) state_nx = (cnt == '0) ? DONE : DIV;
            DIV:  if (bcnt == BW'(SUMW - 1)) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.state_dbg = state;
    end

    assign bus.height       = height_r;
    assign bus.height_valid = height_valid_r;
    assign bus.pairs_used   = pairs_used_r;
    assign bus.fault        = fault_r;

    // Pair k is (sensor k, sensor k+NUM_PAIRS); the extra SCAN cycle at ptr==NUM_PAIRS decides the path.
    always_comb begin
        pa = '0;
        pb = '0;
        for (int k = 0; k < NUM_PAIRS; k++) begin
            if (ptr == PW'(k)) begin
                pa = snap[k*WIDTH +: WIDTH];
                pb = snap[(k+NUM_PAIRS)*WIDTH +: WIDTH];
            end
        end
        pair_ok   = (pa != '0) && (pb != '0);
        scan_last = (ptr == PW'(NUM_PAIRS));
    end

    // One restoring-divide step: num shifts its MSB into rem and takes the quotient bit at its LSB.
    always_comb begin
        rem_sh = {rem, num[SUMW-1]};
        ge     = (rem_sh >= (SUMW+1)'(cnt));
        rem_nx = ge ? SUMW'(rem_sh - (SUMW+1)'(cnt)) : SUMW'(rem_sh);
        num_nx = {num[SUMW-2:0], ge};
        q      = num[WIDTH-1:0];
    end

    // Window sum as it will be after q enters; an empty window is treated as filled with q.
    always_comb begin
        wsum = WSW'(q);
        for (int i = 0; i < DEPTH - 1; i++)
            wsum = wsum + (win_full ? WSW'(win[i]) : WSW'(q));
        height_nx = WIDTH'((wsum + WSW'(DEPTH >> 1)) >> AVG_LOG2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap           <= '0;
            sum            <= '0;
            num            <= '0;
            rem            <= '0;
            cnt            <= '0;
            ptr            <= '0;
            bcnt           <= '0;
            win_full       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
            height_r       <= '0;
            height_valid_r <= 1'b0;
            pairs_used_r   <= '0;
            fault_r        <= 1'b0;
        end else begin
            height_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        snap <= bus.sensors;
                        sum  <= '0;
                        cnt  <= '0;
                        ptr  <= '0;
                    end
                end
                SCAN: begin
                    if (!scan_last) begin
                        if (pair_ok) begin
                            sum <= sum + SUMW'(pa) + SUMW'(pb);
                            cnt <= cnt + CW'(2);
                        end
                        ptr <= ptr + PW'(1);
                    end else begin
                        num  <= sum + SUMW'(cnt >> 1);
                        rem  <= '0;
                        bcnt <= '0;
                    end
                end
                DIV: begin
                    num  <= num_nx;
                    rem  <= rem_nx;
                    bcnt <= bcnt + BW'(1);
                end
                DONE: begin
                    height_valid_r <= 1'b1;
                    pairs_used_r   <= PW'(cnt >> 1);
                    fault_r        <= (cnt == '0);
                    if (cnt != '0) begin
                        win[0]   <= q;
                        for (int i = 1; i < DEPTH; i++)
                            win[i] <= win_full ? win[i-1] : q;
                        win_full <= 1'b1;
                        height_r <= height_nx;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
